// File: rtl/limbus_nios2_qsys_0_nios2_oci_trace_tx_pkg.sv
// ============================================================================
// limbus_nios2_oci_trace_pkg : shared types and defaults for the OCI trace drain
// Rev 1.0
// ============================================================================
`default_nettype none

package limbus_nios2_oci_trace_pkg;

  localparam int TRACE_FRAME_W = 36;
  localparam int TRACE_PIN_W   = 18;

  localparam logic [TRACE_PIN_W-1:0] TRACE_IDLE_PATTERN = 18'h00000;
  localparam logic [TRACE_PIN_W-1:0] TRACE_SYNC_PATTERN = 18'h3FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SEND_LO = 2'd1,
    ST_SEND_HI = 2'd2
  } trace_tx_state_e;

endpackage : limbus_nios2_oci_trace_pkg

`default_nettype wire

// File: rtl/limbus_nios2_qsys_0_nios2_oci_trace_tx_if.sv
// ============================================================================
// limbus_nios2_qsys_0_nios2_oci_trace_tx_if : FIFO read side + trace pin bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface limbus_nios2_qsys_0_nios2_oci_trace_tx_if #(
  parameter int FRAME_W = limbus_nios2_oci_trace_pkg::TRACE_FRAME_W,
  parameter int PIN_W   = limbus_nios2_oci_trace_pkg::TRACE_PIN_W,
  parameter int CNT_W   = 16
) ();

  logic               trc_on;
  logic               fifo_empty;
  logic [FRAME_W-1:0] fifo_rdata;
  logic               fifo_rd;
  logic               tr_ready;
  logic               tr_valid;
  logic [PIN_W-1:0]   tr_data;
  logic               tr_first;
  logic               tr_sync;
  logic [CNT_W-1:0]   frames_sent;

  // master = the drain engine, slave = FIFO / pin driver environment
  modport master (
    input  trc_on, fifo_empty, fifo_rdata, tr_ready,
    output fifo_rd, tr_valid, tr_data, tr_first, tr_sync, frames_sent
  );

  modport slave (
    output trc_on, fifo_empty, fifo_rdata, tr_ready,
    input  fifo_rd, tr_valid, tr_data, tr_first, tr_sync, frames_sent
  );

endinterface : limbus_nios2_qsys_0_nios2_oci_trace_tx_if

`default_nettype wire

// File: rtl/limbus_nios2_qsys_0_nios2_oci_trace_tx.sv
// ============================================================================
// limbus_nios2_qsys_0_nios2_oci_trace_tx : drains 36-bit trace frames as two
// 18-bit halves (low first) with periodic sync-frame insertion.  Rev 1.0
// ============================================================================
`default_nettype none

module limbus_nios2_qsys_0_nios2_oci_trace_tx
  import limbus_nios2_oci_trace_pkg::*;
#(
  parameter int               FRAME_W       = TRACE_FRAME_W,
  parameter int               PIN_W         = TRACE_PIN_W,
  parameter logic [PIN_W-1:0] IDLE_PATTERN  = TRACE_IDLE_PATTERN,
  parameter logic [PIN_W-1:0] SYNC_PATTERN  = TRACE_SYNC_PATTERN,
  parameter int               SYNC_INTERVAL = 64,
  parameter int               CNT_W         = 16
) (
  input  logic clk,
  input  logic jrst_n,
  limbus_nios2_qsys_0_nios2_oci_trace_tx_if.master bus
);

  localparam int             SC_W     = (SYNC_INTERVAL > 0) ? $clog2(SYNC_INTERVAL + 1) : 1;
  localparam logic [SC_W-1:0] SYNC_MAX = SC_W'(SYNC_INTERVAL);
  localparam bit             SYNC_EN  = (SYNC_INTERVAL != 0);

  trace_tx_state_e    state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               tr_valid_q, tr_valid_d;
  logic [PIN_W-1:0]   tr_data_q, tr_data_d;
  logic               tr_first_q, tr_first_d;
  logic               tr_sync_q, tr_sync_d;
  logic [CNT_W-1:0]   frames_q, frames_d;
  logic [SC_W-1:0]    sync_cnt_q, sync_cnt_d;

  logic               frame_done;
  logic               can_start;
  logic [SC_W-1:0]    sync_cnt_upd;
  logic               sync_due;
  logic               start_sync;
  logic               start_data;

  // The sync decision sees the count already bumped by a frame finishing this
  // cycle, so a due sync follows the last data frame without an idle gap.
  always_comb begin
    frame_done   = (state_q == ST_SEND_HI) && bus.tr_ready;
    can_start    = (state_q == ST_IDLE) || frame_done;
    sync_cnt_upd = sync_cnt_q;
    if (frame_done && !tr_sync_q && (sync_cnt_q < SYNC_MAX)) begin
      sync_cnt_upd = sync_cnt_q + 1'b1;
    end
    sync_due   = SYNC_EN && (sync_cnt_upd == SYNC_MAX);
    start_sync = jrst_n && can_start && bus.trc_on && sync_due;
    start_data = jrst_n && can_start && bus.trc_on && !sync_due && !bus.fifo_empty;
  end

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    tr_valid_d = tr_valid_q;
    tr_data_d  = tr_data_q;
    tr_first_d = tr_first_q;
    tr_sync_d  = tr_sync_q;
    frames_d   = frames_q;
    sync_cnt_d = sync_cnt_upd;

    case (state_q)
      ST_SEND_LO: begin
        if (bus.tr_ready) begin
          state_d    = ST_SEND_HI;
          tr_data_d  = frame_q[FRAME_W-1:PIN_W];
          tr_first_d = 1'b0;
        end
      end
      ST_SEND_HI: begin
        if (bus.tr_ready) begin
          if (!tr_sync_q) begin
            frames_d = frames_q + 1'b1;
          end
          state_d    = ST_IDLE;
          tr_valid_d = 1'b0;
          tr_data_d  = IDLE_PATTERN;
          tr_first_d = 1'b0;
          tr_sync_d  = 1'b0;
        end
      end
      default: ;
    endcase

    // A new frame start overrides the idle fall-back chosen above.
    if (start_sync) begin
      state_d    = ST_SEND_LO;
      frame_d    = {SYNC_PATTERN, SYNC_PATTERN};
      sync_cnt_d = '0;
      tr_valid_d = 1'b1;
      tr_data_d  = SYNC_PATTERN;
      tr_first_d = 1'b1;
      tr_sync_d  = 1'b1;
    end else if (start_data) begin
      state_d    = ST_SEND_LO;
      frame_d    = bus.fifo_rdata;
      tr_valid_d = 1'b1;
      tr_data_d  = bus.fifo_rdata[PIN_W-1:0];
      tr_first_d = 1'b1;
      tr_sync_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      tr_valid_q <= 1'b0;
      tr_data_q  <= IDLE_PATTERN;
      tr_first_q <= 1'b0;
      tr_sync_q  <= 1'b0;
      frames_q   <= '0;
      sync_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      tr_valid_q <= tr_valid_d;
      tr_data_q  <= tr_data_d;
      tr_first_q <= tr_first_d;
      tr_sync_q  <= tr_sync_d;
      frames_q   <= frames_d;
      sync_cnt_q <= sync_cnt_d;
    end
  end

  assign bus.fifo_rd     = start_data;
  assign bus.tr_valid    = tr_valid_q;
  assign bus.tr_data     = tr_data_q;
  assign bus.tr_first    = tr_first_q;
  assign bus.tr_sync     = tr_sync_q;
  assign bus.frames_sent = frames_q;

endmodule : limbus_nios2_qsys_0_nios2_oci_trace_tx

`default_nettype wire

// File: tb/tb_limbus_nios2_qsys_0_nios2_oci_trace_tx.sv
// ============================================================================
// tb_limbus_nios2_qsys_0_nios2_oci_trace_tx : directed + randomized bench with
// a frame-stream scoreboard.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_limbus_nios2_qsys_0_nios2_oci_trace_tx;
  import limbus_nios2_oci_trace_pkg::*;

  localparam int N_SYNC = 3;

  typedef struct packed {
    logic [17:0] data;
    logic        first;
    logic        sync;
  } half_t;

  logic clk    = 1'b0;
  logic jrst_n = 1'b0;

  always #5 clk = ~clk;

  limbus_nios2_qsys_0_nios2_oci_trace_tx_if ifc ();

  limbus_nios2_qsys_0_nios2_oci_trace_tx #(
    .SYNC_INTERVAL (N_SYNC)
  ) u_dut (
    .clk    (clk),
    .jrst_n (jrst_n),
    .bus    (ifc)
  );

  logic [35:0] fifo_q[$];
  half_t       exp_q[$];
  int          n_sched;
  logic [15:0] model_frames;
  int          n_checks;
  int          n_err;
  int          pops;
  bit          last_rd;
  bit          prev_rd;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected stream: every data frame as lo/hi, and a sync frame after every
  // N_SYNC data frames since reset.
  function automatic void sched(input logic [35:0] f);
    exp_q.push_back('{f[17:0], 1'b1, 1'b0});
    exp_q.push_back('{f[35:18], 1'b0, 1'b0});
    n_sched++;
    if (n_sched == N_SYNC) begin
      exp_q.push_back('{TRACE_SYNC_PATTERN, 1'b1, 1'b1});
      exp_q.push_back('{TRACE_SYNC_PATTERN, 1'b0, 1'b1});
      n_sched = 0;
    end
  endfunction

  task automatic push(input logic [35:0] f);
    fifo_q.push_back(f);
    sched(f);
  endtask

  task automatic drive_fifo();
    ifc.fifo_empty = (fifo_q.size() == 0);
    ifc.fifo_rdata = (fifo_q.size() != 0) ? fifo_q[0] : 36'h0;
  endtask

  task automatic monitor();
    last_rd = ifc.fifo_rd;
    chk("frames_sent", ifc.frames_sent, model_frames);
    if (ifc.fifo_rd) begin
      chk("rd_nonempty", ifc.fifo_empty, 1'b0);
      pops++;
    end
    if (prev_rd) chk("pop_latency", {ifc.tr_valid, ifc.tr_first}, 2'b11);
    prev_rd = ifc.fifo_rd;
    if (ifc.tr_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", ifc.tr_valid, 1'b0);
      end else begin
        chk("half_data", ifc.tr_data, exp_q[0].data);
        chk("half_first", ifc.tr_first, exp_q[0].first);
        chk("half_sync", ifc.tr_sync, exp_q[0].sync);
        if (ifc.tr_ready) begin
          if (!exp_q[0].first && !exp_q[0].sync) model_frames++;
          void'(exp_q.pop_front());
        end
      end
    end else begin
      chk("idle_data", ifc.tr_data, TRACE_IDLE_PATTERN);
    end
  endtask

  task automatic tick(input bit rdy, input bit on);
    @(negedge clk);
    ifc.tr_ready = rdy;
    ifc.trc_on   = on;
    drive_fifo();
    #1;
    monitor();
    @(posedge clk);
    #1;
    if (last_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
  endtask

  // Asserts reset immediately (asynchronously) and rebuilds the model from
  // whatever is still queued in the FIFO.
  task automatic do_reset(input bit keep_fifo);
    if (!keep_fifo) fifo_q.delete();
    jrst_n       = 1'b0;
    ifc.trc_on   = 1'b0;
    ifc.tr_ready = 1'b0;
    #1;
    chk("rst_valid", ifc.tr_valid, 1'b0);
    chk("rst_data", ifc.tr_data, TRACE_IDLE_PATTERN);
    chk("rst_first", ifc.tr_first, 1'b0);
    chk("rst_sync", ifc.tr_sync, 1'b0);
    chk("rst_frames", ifc.frames_sent, 16'h0);
    chk("rst_rd", ifc.fifo_rd, 1'b0);
    repeat (2) @(negedge clk);
    jrst_n = 1'b1;
    exp_q.delete();
    n_sched      = 0;
    model_frames = 16'h0;
    prev_rd      = 1'b0;
    foreach (fifo_q[i]) sched(fifo_q[i]);
  endtask

  task automatic drain(input int budget);
    int cyc;
    cyc = 0;
    while ((exp_q.size() != 0 || ifc.tr_valid) && cyc < budget) begin
      tick($urandom_range(0, 3) != 0, 1'b1);
      cyc++;
    end
    chk("drain_stream", exp_q.size(), 0);
    chk("drain_fifo", fifo_q.size(), 0);
  endtask

  initial begin
    logic [35:0] f;
    int          run;

    n_checks     = 0;
    n_err        = 0;
    pops         = 0;
    n_sched      = 0;
    model_frames = 16'h0;
    prev_rd      = 1'b0;
    last_rd      = 1'b0;
    ifc.trc_on     = 1'b0;
    ifc.tr_ready   = 1'b0;
    ifc.fifo_empty = 1'b1;
    ifc.fifo_rdata = 36'h0;

    // single frame: pop, low half, high half, count
    do_reset(1'b0);
    f = 36'h1_2345_6789;
    push(f);
    tick(1'b1, 1'b1);
    chk("t1_rd", last_rd, 1'b1);
    chk("t1_lo_data", ifc.tr_data, f[17:0]);
    chk("t1_lo_first", ifc.tr_first, 1'b1);
    tick(1'b1, 1'b1);
    chk("t1_hi_data", ifc.tr_data, f[35:18]);
    chk("t1_hi_first", ifc.tr_first, 1'b0);
    tick(1'b1, 1'b1);
    chk("t1_frames", ifc.frames_sent, 16'd1);
    chk("t1_idle", ifc.tr_valid, 1'b0);

    // back-to-back frames with a sync inserted after the third
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) push({4'(i), 32'hA5A5_0000 + 32'(i)});
    tick(1'b1, 1'b1);
    pops = 0;
    run  = 1;
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 1'b1);
      if (ifc.tr_valid) run++;
    end
    chk("t2_no_gap", run, 8);
    chk("t2_pops", pops, 2);
    drain(200);
    chk("t2_frames", ifc.frames_sent, 16'd4);

    // stall in the low half
    do_reset(1'b0);
    push(36'h9_8765_4321);
    push(36'h0_0F0F_F0F0);
    tick(1'b1, 1'b1);
    pops = 0;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    chk("t4_stall_rd", pops, 0);
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    drain(200);
    chk("t4_frames", ifc.frames_sent, 16'd2);

    // trace disabled mid-frame
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) push({4'hC, 32'(i * 7 + 3)});
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    pops = 0;
    repeat (4) tick(1'b1, 1'b0);
    chk("t5_pops", pops, 0);
    chk("t5_idle", ifc.tr_valid, 1'b0);
    chk("t5_frames", ifc.frames_sent, 16'd1);
    chk("t5_fifo_left", fifo_q.size(), 2);
    drain(200);

    // reset while sending the high half
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) push({4'h3, 32'h1000_0000 * 32'(i + 1)});
    tick(1'b1, 1'b1);
    tick(1'b1, 1'b1);
    chk("t6_in_hi", {ifc.tr_valid, ifc.tr_first}, 2'b10);
    #2;
    do_reset(1'b1);
    drain(200);
    chk("t6_frames", ifc.frames_sent, 16'd2);

    // randomized traffic
    do_reset(1'b0);
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 4 && fifo_q.size() < 8) begin
        f[31:0]  = $urandom();
        f[35:32] = 4'($urandom());
        push(f);
      end
      tick($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9);
    end
    drain(3000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_limbus_nios2_qsys_0_nios2_oci_trace_tx

`default_nettype wire
